// File: rtl/universal_shift_register_n.sv
// Parametrised universal shift/rotate register with single-step modes and a
// multi-cycle burst shift that reports progress through busy and a done pulse.
module universal_shift_register_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in_lsb,
    input  logic             ser_in_msb,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        StIdle,
        StBurst
    } state_e;

    localparam logic [2:0] ModeHold = 3'b000;
    localparam logic [2:0] ModeLoad = 3'b001;
    localparam logic [2:0] ModeShl  = 3'b010;
    localparam logic [2:0] ModeShr  = 3'b011;
    localparam logic [2:0] ModeRol  = 3'b100;
    localparam logic [2:0] ModeRor  = 3'b101;
    localparam logic [2:0] ModeAsr  = 3'b110;
    localparam logic [2:0] ModeClr  = 3'b111;

    state_e           state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             done_q, done_d;
    logic             shift_mode;

    // One step of the given operation applied to the current contents.
    function automatic logic [WIDTH-1:0] step_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             sil,
        input logic             sim
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (op)
            ModeHold: res = cur;
            ModeLoad: res = ld;
            ModeShl:  res = {cur[WIDTH-2:0], sil};
            ModeShr:  res = {sim, cur[WIDTH-1:1]};
            ModeRol:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            ModeRor:  res = {cur[0], cur[WIDTH-1:1]};
            ModeAsr:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            ModeClr:  res = '0;
            default:  res = cur;
        endcase
        return res;
    endfunction

    // Only shift/rotate modes can be burst; hold/load/clear stay single-step.
    assign shift_mode = (mode >= ModeShl) && (mode <= ModeAsr);

    // Next-state: single steps and burst launch in idle, one latched step per cycle in burst.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start && shift_mode) begin
                    if (count != '0) begin
                        mode_d  = mode;
                        cnt_d   = count;
                        state_d = StBurst;
                    end else begin
                        // Empty burst completes immediately without touching q.
                        done_d = 1'b1;
                    end
                end else if (start || en) begin
                    q_d = step_op(mode, q_q, d, ser_in_lsb, ser_in_msb);
                end
            end
            StBurst: begin
                q_d   = step_op(mode_q, q_q, d, ser_in_lsb, ser_in_msb);
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            mode_q  <= ModeHold;
            cnt_q   <= '0;
            q_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            done_q  <= done_d;
        end
    end

    assign q           = q_q;
    assign ser_out_msb = q_q[WIDTH-1];
    assign ser_out_lsb = q_q[0];
    assign busy        = (state_q == StBurst);
    assign done        = done_q;

endmodule

// File: doc/universal_shift_register_n.md
Name: universal_shift_register_n

Overview:
- Parametrised, WIDTH-bit universal shift/rotate register. It replaces the fixed 4-bit universal shift register.
- Adds explicit mode encoding, serial in/out at both ends, rotate and arithmetic-shift modes, and a multi-cycle burst shift with a busy/done handshake.
- Used as the datapath shifter for serial links and bit-manipulation exercises.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- CNT_W, 4, width of the burst shift count (max burst = 2^CNT_W - 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  enables a single-step operation in IDLE.
- mode  input  3  operation select (encoding below).
- d  input  WIDTH  parallel load data.
- ser_in_lsb  input  1  bit shifted into q[0] on shift-left.
- ser_in_msb  input  1  bit shifted into q[WIDTH-1] on shift-right.
- start  input  1  request a burst of count shifts using mode.
- count  input  CNT_W  number of single-bit steps for a burst.
- q  output  WIDTH  register contents.
- ser_out_msb  output  1  q[WIDTH-1], combinational.
- ser_out_lsb  output  1  q[0], combinational.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Mode encoding, one step each:
  - 000 hold.
  - 001 load: q <= d.
  - 010 SHL: q <= {q[W-2:0], ser_in_lsb}.
  - 011 SHR: q <= {ser_in_msb, q[W-1:1]}.
  - 100 ROL: q <= {q[W-2:0], q[W-1]}.
  - 101 ROR: q <= {q[0], q[W-1:1]}.
  - 110 ASR: q <= {q[W-1], q[W-1:1]}.
  - 111 clear: q <= 0.
- Reset (asynchronous, any time, including mid-burst): q=0, busy=0, done=0, state IDLE, remaining count=0.
- State machine has two states, IDLE and BURST.
- IDLE, start=1 with mode in 010..110 and count>0:
  - At edge k, latch mode and count; busy<=1; q unchanged at edge k.
  - Enter BURST.
- IDLE, start=1 with mode in 010..110 and count=0:
  - done<=1 at edge k; busy stays 0; q unchanged.
- IDLE, start=1 with mode 000, 001 or 111: treated as a single-step op (same as en=1); no burst, no done.
- IDLE, start=0, en=1: perform one mode op at the edge.
- IDLE, start=0, en=0: hold.
- start has priority over en when both are high.
- BURST:
  - One step of the latched mode on each edge k+1 .. k+count.
  - ser_in_lsb/ser_in_msb are sampled live at each step edge.
  - At edge k+count: busy<=0, done<=1, return to IDLE.
  - done deasserts at the next edge unless a count=0 start re-asserts it.
  - While in BURST, en, mode, start, d and count are ignored.
- busy is high for exactly count cycles. done is high for exactly 1 cycle.
- A new start is accepted in the cycle done is high (the state is IDLE).
- Bursts with count > WIDTH are legal:
  - Rotates wrap.
  - SHL/SHR fill the register entirely from the serial inputs.
  - ASR saturates to all-sign.
- ser_out_msb and ser_out_lsb always reflect the current q; there are no registered copies.

Test Plan:
(All scenarios use WIDTH=8, CNT_W=4.)
1. Reset, then en=1 mode=001 d=0xA5 -> q=0xA5. Then mode=010 with ser_in_lsb=0 -> q=0x4A. Then mode=011 with ser_in_msb=1 -> q=0xA5, ser_out_lsb=1, ser_out_msb=1.
2. q=0xA5, start=1 mode=100 count=3 -> busy high 3 cycles; q steps 0x4B, 0x96, 0x2D; done pulses 1 cycle together with busy falling; final q=0x2D.
3. q=0x90, start=1 mode=110 count=4 -> q=0xF9 after 4 steps; done pulse. Repeat with count=12 -> q=0xFF.
4. start=1 mode=010 count=0 -> done high in the next cycle only; busy never high; q unchanged. Also: start and en pulsed with mode=001 d=0x00 mid-burst -> ignored, burst result unaffected.
5. Burst mode=011 count=8 on q=0x00 with ser_in_msb=1 every step -> q=0xFF; with ser_in_msb alternating 1,0 from step 1 -> q=0x55.
6. Assert reset asynchronously (between edges) at step 2 of a count=5 ROL burst -> q=0, busy=0, done=0 immediately. After release, the remaining steps do not resume; a fresh start is accepted.
